// File: rtl/alarm_ctrl.sv
// Alarm clock controller: HH:MM:SS timekeeping, set modes via mode/inc buttons,
// and a ring/snooze alarm FSM driven by the 1 Hz tick.
module alarm_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic       z60,
  input  logic       rst,
  input  logic       tick,
  output logic       div_clr,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_snooze,
  input  logic       alm_en,
  output logic [4:0] time_hr,
  output logic [5:0] time_min,
  output logic [5:0] time_sec,
  output logic [4:0] alm_hr,
  output logic [5:0] alm_min,
  output logic [2:0] mode,
  output logic       alarm_on
);

  localparam logic [2:0] M_RUN      = 3'd0;
  localparam logic [2:0] M_SET_T_HR = 3'd1;
  localparam logic [2:0] M_SET_T_MIN = 3'd2;
  localparam logic [2:0] M_SET_A_HR = 3'd3;
  localparam logic [2:0] M_SET_A_MIN = 3'd4;

  localparam logic [1:0] A_IDLE   = 2'd0;
  localparam logic [1:0] A_RING   = 2'd1;
  localparam logic [1:0] A_SNOOZE = 2'd2;

  localparam logic [8:0] RING_CNT   = 9'(RING_SEC);
  localparam logic [8:0] SNOOZE_CNT = 9'(SNOOZE_SEC);

  logic [4:0] time_hr_q, time_hr_d;
  logic [5:0] time_min_q, time_min_d;
  logic [5:0] time_sec_q, time_sec_d;
  logic [4:0] alm_hr_q, alm_hr_d;
  logic [5:0] alm_min_q, alm_min_d;
  logic [2:0] mode_q, mode_d;
  logic [1:0] a_state_q, a_state_d;
  logic [8:0] cnt_q, cnt_d;
  logic       alarm_on_q, alarm_on_d;
  logic       div_clr_q, div_clr_d;
  logic       tick_upd_q, tick_upd_d;
  logic       time_runs;
  logic       alarm_match;

  assign time_runs = (mode_q == M_RUN) || (mode_q == M_SET_A_HR) || (mode_q == M_SET_A_MIN);

  // Match is evaluated on the registered time, so it fires the cycle after the tick update.
  assign alarm_match = tick_upd_q && (time_hr_q == alm_hr_q) && (time_min_q == alm_min_q)
                       && (time_sec_q == 6'd0);

  always_comb begin
    time_hr_d  = time_hr_q;
    time_min_d = time_min_q;
    time_sec_d = time_sec_q;
    alm_hr_d   = alm_hr_q;
    alm_min_d  = alm_min_q;
    mode_d     = mode_q;
    div_clr_d  = 1'b0;
    tick_upd_d = 1'b0;

    if (tick && time_runs) begin
      tick_upd_d = 1'b1;
      if (time_sec_q == 6'd59) begin
        time_sec_d = 6'd0;
        if (time_min_q == 6'd59) begin
          time_min_d = 6'd0;
          time_hr_d  = (time_hr_q == 5'd23) ? 5'd0 : time_hr_q + 5'd1;
        end else begin
          time_min_d = time_min_q + 6'd1;
        end
      end else begin
        time_sec_d = time_sec_q + 6'd1;
      end
    end

    if (btn_mode) begin
      mode_d = (mode_q >= M_SET_A_MIN) ? M_RUN : mode_q + 3'd1;
      if (mode_q == M_SET_T_MIN) begin
        time_sec_d = 6'd0;
        div_clr_d  = 1'b1;
      end
    end else if (btn_inc) begin
      case (mode_q)
        M_SET_T_HR:  time_hr_d  = (time_hr_q == 5'd23)  ? 5'd0 : time_hr_q + 5'd1;
        M_SET_T_MIN: time_min_d = (time_min_q == 6'd59) ? 6'd0 : time_min_q + 6'd1;
        M_SET_A_HR:  alm_hr_d   = (alm_hr_q == 5'd23)   ? 5'd0 : alm_hr_q + 5'd1;
        M_SET_A_MIN: alm_min_d  = (alm_min_q == 6'd59)  ? 6'd0 : alm_min_q + 6'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    a_state_d = a_state_q;
    cnt_d     = cnt_q;
    if (!alm_en) begin
      a_state_d = A_IDLE;
      cnt_d     = 9'd0;
    end else begin
      case (a_state_q)
        A_IDLE: begin
          if (alarm_match) begin
            a_state_d = A_RING;
            cnt_d     = RING_CNT;
          end
        end
        A_RING: begin
          if (btn_snooze) begin
            a_state_d = A_SNOOZE;
            cnt_d     = SNOOZE_CNT;
          end else if (tick) begin
            if (cnt_q <= 9'd1) begin
              a_state_d = A_IDLE;
              cnt_d     = 9'd0;
            end else begin
              cnt_d = cnt_q - 9'd1;
            end
          end
        end
        A_SNOOZE: begin
          if (tick) begin
            if (cnt_q <= 9'd1) begin
              a_state_d = A_RING;
              cnt_d     = RING_CNT;
            end else begin
              cnt_d = cnt_q - 9'd1;
            end
          end
        end
        default: begin
          a_state_d = A_IDLE;
          cnt_d     = 9'd0;
        end
      endcase
    end
    alarm_on_d = (a_state_d == A_RING);
  end

  always_ff @(posedge z60) begin
    if (rst) begin
      time_hr_q  <= 5'd0;
      time_min_q <= 6'd0;
      time_sec_q <= 6'd0;
      alm_hr_q   <= 5'd0;
      alm_min_q  <= 6'd0;
      mode_q     <= M_RUN;
      a_state_q  <= A_IDLE;
      cnt_q      <= 9'd0;
      alarm_on_q <= 1'b0;
      div_clr_q  <= 1'b0;
      tick_upd_q <= 1'b0;
    end else begin
      time_hr_q  <= time_hr_d;
      time_min_q <= time_min_d;
      time_sec_q <= time_sec_d;
      alm_hr_q   <= alm_hr_d;
      alm_min_q  <= alm_min_d;
      mode_q     <= mode_d;
      a_state_q  <= a_state_d;
      cnt_q      <= cnt_d;
      alarm_on_q <= alarm_on_d;
      div_clr_q  <= div_clr_d;
      tick_upd_q <= tick_upd_d;
    end
  end

  assign time_hr  = time_hr_q;
  assign time_min = time_min_q;
  assign time_sec = time_sec_q;
  assign alm_hr   = alm_hr_q;
  assign alm_min  = alm_min_q;
  assign mode     = mode_q;
  assign alarm_on = alarm_on_q;
  assign div_clr  = div_clr_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: a vector table for single-cycle behaviour
// plus hand-written sequences for time wrap, alarm ring, snooze and reset.
module tb_alarm_ctrl;

  logic       z60 = 1'b0;
  logic       rst, tick, btn_mode, btn_inc, btn_snooze, alm_en;
  logic       div_clr, alarm_on;
  logic [4:0] time_hr, alm_hr;
  logic [5:0] time_min, time_sec, alm_min;
  logic [2:0] mode;

  int n_tests = 0;
  int n_fail  = 0;

  alarm_ctrl #(.RING_SEC(60), .SNOOZE_SEC(300)) dut (
    .z60(z60), .rst(rst), .tick(tick), .div_clr(div_clr),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_snooze(btn_snooze), .alm_en(alm_en),
    .time_hr(time_hr), .time_min(time_min), .time_sec(time_sec),
    .alm_hr(alm_hr), .alm_min(alm_min), .mode(mode), .alarm_on(alarm_on)
  );

  always #5 z60 = ~z60;

  typedef struct {
    logic rst, tick, bm, bi, bs, en;
    int   e_hr, e_min, e_sec, e_ahr, e_amin, e_mode, e_div, e_al;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock with the given button pulses; outputs are stable 1 ns after the edge.
  task automatic cyc(input logic t, input logic bm, input logic bi, input logic bs);
    tick = t; btn_mode = bm; btn_inc = bi; btn_snooze = bs;
    @(posedge z60);
    #1;
    tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_snooze = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0);
  endtask

  // Leaves time 07:30:00, alarm 07:30, RUN, ringing with a fresh 60 s count.
  task automatic start_ring();
    alm_en = 1'b0;
    do_reset();
    cyc(0, 1, 0, 0); incs(7);
    cyc(0, 1, 0, 0); incs(29);
    cyc(0, 1, 0, 0); incs(7);
    cyc(0, 1, 0, 0); incs(30);
    cyc(0, 1, 0, 0);
    ticks(59);
    check("pre_alarm_time", {time_hr, time_min, time_sec}, {5'd7, 6'd29, 6'd59});
    alm_en = 1'b1;
    cyc(1, 0, 0, 0);
    check("match_time", {time_hr, time_min, time_sec}, {5'd7, 6'd30, 6'd0});
    check("alarm_not_yet", alarm_on, 0);
    cyc(0, 0, 0, 0);
    check("alarm_rings", alarm_on, 1);
    $display("[TB] ring started at %0d:%0d:%0d alarm_on=%0d", time_hr, time_min, time_sec, alarm_on);
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_snooze = 1'b0; alm_en = 1'b0;
    //          rst tick bm bi bs en   hr min sec ahr amin mode div al
    vecs[0]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 0, 0,  0, 0, 2, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 1, 0, 0,  0, 0, 2, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 0, 0, 0,  0, 0, 2, 0, 0, 1, 0, 0};
    vecs[5]  = '{0, 1, 0, 0, 0, 0,  0, 0, 2, 0, 0, 1, 0, 0};
    vecs[6]  = '{0, 0, 0, 1, 0, 0,  1, 0, 2, 0, 0, 1, 0, 0};
    vecs[7]  = '{0, 0, 1, 1, 0, 0,  1, 0, 2, 0, 0, 2, 0, 0};
    vecs[8]  = '{0, 0, 0, 1, 0, 0,  1, 1, 2, 0, 0, 2, 0, 0};
    vecs[9]  = '{0, 1, 0, 0, 0, 0,  1, 1, 2, 0, 0, 2, 0, 0};
    vecs[10] = '{0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 3, 1, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 3, 0, 0};
    vecs[12] = '{0, 1, 0, 0, 0, 0,  1, 1, 1, 0, 0, 3, 0, 0};
    vecs[13] = '{0, 0, 0, 1, 0, 0,  1, 1, 1, 1, 0, 3, 0, 0};
    vecs[14] = '{0, 0, 1, 0, 0, 0,  1, 1, 1, 1, 0, 4, 0, 0};
    vecs[15] = '{0, 1, 0, 1, 0, 0,  1, 1, 2, 1, 1, 4, 0, 0};
    vecs[16] = '{0, 0, 1, 0, 0, 0,  1, 1, 2, 1, 1, 0, 0, 0};
    vecs[17] = '{0, 0, 0, 0, 1, 1,  1, 1, 2, 1, 1, 0, 0, 0};
    vecs[18] = '{1, 1, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 19; i++) begin
      rst = vecs[i].rst; alm_en = vecs[i].en;
      cyc(vecs[i].tick, vecs[i].bm, vecs[i].bi, vecs[i].bs);
      $display("[TB] vec %0d: %0d:%0d:%0d alm %0d:%0d mode=%0d div_clr=%0d alarm_on=%0d",
               i, time_hr, time_min, time_sec, alm_hr, alm_min, mode, div_clr, alarm_on);
      check($sformatf("v%0d_hr", i), time_hr, vecs[i].e_hr);
      check($sformatf("v%0d_min", i), time_min, vecs[i].e_min);
      check($sformatf("v%0d_sec", i), time_sec, vecs[i].e_sec);
      check($sformatf("v%0d_ahr", i), alm_hr, vecs[i].e_ahr);
      check($sformatf("v%0d_amin", i), alm_min, vecs[i].e_amin);
      check($sformatf("v%0d_mode", i), mode, vecs[i].e_mode);
      check($sformatf("v%0d_div", i), div_clr, vecs[i].e_div);
      check($sformatf("v%0d_alarm", i), alarm_on, vecs[i].e_al);
    end
    rst = 1'b0; alm_en = 1'b0;

    // Hour setting wraps, set modes freeze time, leaving SET_T_MIN zeroes seconds.
    do_reset();
    ticks(5);
    cyc(0, 1, 0, 0); incs(22);
    check("set_hr_22", time_hr, 22);
    incs(3);
    check("set_hr_wrap", time_hr, 1);
    ticks(2);
    check("frozen_sec_hr", time_sec, 5);
    cyc(0, 1, 0, 0); ticks(2);
    check("frozen_sec_min", {time_hr, time_min, time_sec}, {5'd1, 6'd0, 6'd5});
    cyc(0, 1, 0, 0);
    check("step_sec0", time_sec, 0);
    check("step_div_clr", div_clr, 1);
    check("step_mode", mode, 3);
    cyc(0, 0, 0, 0);
    check("div_clr_one_cycle", div_clr, 0);
    $display("[TB] set sequence: %0d:%0d:%0d mode=%0d", time_hr, time_min, time_sec, mode);

    // Full-day rollover from 23:59:59.
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0); incs(22);
    cyc(0, 1, 0, 0); incs(59);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    check("run_mode", mode, 0);
    ticks(59);
    check("at_235959", {time_hr, time_min, time_sec}, {5'd23, 6'd59, 6'd59});
    cyc(1, 0, 0, 0);
    check("rollover", {time_hr, time_min, time_sec}, 17'd0);
    $display("[TB] rollover: %0d:%0d:%0d", time_hr, time_min, time_sec);

    // Ring times out after 60 ticks.
    start_ring();
    ticks(59);
    check("ring_59", alarm_on, 1);
    ticks(1);
    check("ring_end", alarm_on, 0);
    cyc(0, 0, 0, 1);
    check("snooze_idle_ignored", alarm_on, 0);
    ticks(3);
    check("no_retrigger", alarm_on, 0);

    // Snooze, re-ring after 300 ticks with a fresh 60 s count.
    start_ring();
    cyc(0, 0, 0, 1);
    check("snooze_off", alarm_on, 0);
    ticks(299);
    check("snooze_299", alarm_on, 0);
    ticks(1);
    check("snooze_rering", alarm_on, 1);
    ticks(59);
    check("rering_59", alarm_on, 1);
    // Snooze beats the expiring tick.
    cyc(1, 0, 0, 1);
    check("snooze_vs_expire", alarm_on, 0);
    ticks(299);
    check("snooze2_299", alarm_on, 0);
    ticks(1);
    check("snooze2_rering", alarm_on, 1);

    // Mode edits do not stop the ring; alm_en low kills it with no retrigger.
    start_ring();
    cyc(0, 1, 0, 0);
    check("ring_in_set", alarm_on, 1);
    check("ring_set_mode", mode, 1);
    alm_en = 1'b0;
    cyc(1, 0, 0, 1);
    check("disable_off", alarm_on, 0);
    alm_en = 1'b1;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    check("reenable_no_trig", alarm_on, 0);

    // Reset during snooze with tick and inc present.
    start_ring();
    cyc(0, 0, 0, 1);
    rst = 1'b1;
    cyc(1, 0, 1, 0);
    rst = 1'b0;
    check("rst_time", {time_hr, time_min, time_sec}, 17'd0);
    check("rst_alarm", {alm_hr, alm_min}, 11'd0);
    check("rst_mode", mode, 0);
    check("rst_div", div_clr, 0);
    check("rst_alarm_on", alarm_on, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    check("post_rst_alarm_on", alarm_on, 0);
    check("post_rst_div", div_clr, 0);
    $display("[TB] after reset: %0d:%0d:%0d alarm_on=%0d", time_hr, time_min, time_sec, alarm_on);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter RING_SEC, default 60, alarm ring duration in seconds.
REQ-002 SHALL have parameter SNOOZE_SEC, default 300, snooze duration in seconds.
REQ-003 SHALL have port z60  in  1  system clock; all state updates on posedge z60.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port tick  in  1  one-cycle 1 Hz enable from the seconds divider.
REQ-006 SHALL have port div_clr  out  1  one-cycle pulse that clears the seconds divider.
REQ-007 SHALL have ports btn_mode, btn_inc, btn_snooze  in  1 each  debounced one-cycle button pulses.
REQ-008 SHALL have port alm_en  in  1  alarm enable, level.
REQ-009 SHALL have ports time_hr/time_min/time_sec  out  5/6/6  current time, binary: 0-23, 0-59, 0-59.
REQ-010 SHALL have ports alm_hr/alm_min  out  5/6  alarm setpoint, binary.
REQ-011 SHALL have port mode  out  3  0 RUN, 1 SET_T_HR, 2 SET_T_MIN, 3 SET_A_HR, 4 SET_A_MIN.
REQ-012 SHALL have port alarm_on  out  1  buzzer drive, high only in alarm state RING.

Function
REQ-013 All outputs SHALL be registered; a tick sampled at edge N updates time at edge N.
REQ-014 In RUN, SET_A_HR and SET_A_MIN, each tick SHALL advance time: sec 59->0 carries min; min 59->0 carries hr; 23:59:59->00:00:00.
REQ-015 In SET_T_HR and SET_T_MIN, tick SHALL be ignored (time frozen).
REQ-016 btn_mode SHALL step mode RUN->SET_T_HR->SET_T_MIN->SET_A_HR->SET_A_MIN->RUN.
REQ-017 On the SET_T_MIN->SET_A_HR step, time_sec SHALL load 0 and div_clr SHALL pulse high for exactly that one cycle.
REQ-018 btn_inc SHALL increment the field selected by mode (SET_T_HR: time_hr, etc.), wrapping hr 23->0, min 59->0, no carry; ignored in RUN.
REQ-019 btn_mode and btn_inc in the same cycle: mode step wins, inc dropped.
REQ-020 Alarm FSM states: A_IDLE, A_RING, A_SNOOZE; internal 9-bit seconds down-counter cnt.
REQ-021 A_IDLE->A_RING, cnt<=RING_SEC, in the cycle after a tick-driven time update that yields time_hr==alm_hr, time_min==alm_min, time_sec==0, with alm_en=1; no trigger from set-mode edits or reset.
REQ-022 In A_RING, tick SHALL decrement cnt; at cnt reaching 0 -> A_IDLE.
REQ-023 In A_RING, btn_snooze SHALL go to A_SNOOZE, cnt<=SNOOZE_SEC; btn_snooze in A_IDLE or A_SNOOZE ignored.
REQ-024 In A_SNOOZE, tick SHALL decrement cnt; at cnt reaching 0 -> A_RING, cnt<=RING_SEC.
REQ-025 alm_en=0 SHALL force A_IDLE next edge from any state, overriding tick and btn_snooze.
REQ-026 btn_snooze and a cnt-expiring tick in A_RING same cycle: snooze wins.
REQ-027 Alarm FSM SHALL keep running in all modes; alarm edits do not cancel RING/SNOOZE.

Reset
REQ-028 rst SHALL, at next edge, set time 00:00:00, alarm 00:00, mode RUN, A_IDLE, cnt 0, alarm_on 0, div_clr 0; rst overrides all inputs.
REQ-029 rst asserted mid-RING or mid-set SHALL abort to the reset state with no div_clr pulse and no alarm trigger on release.

Verification
REQ-030 Time 23:59:59, RUN, tick -> 00:00:00 next cycle.
REQ-031 Mode to SET_T_HR, 3x btn_inc from 22 -> time_hr 1; ticks during SET_T_* -> time unchanged; step to SET_A_HR -> time_sec 0, div_clr one cycle.
REQ-032 Alarm 07:30, alm_en 1, time 07:29:59, tick -> alarm_on 1 one cycle after time shows 07:30:00; 60 ticks later alarm_on 0.
REQ-033 In A_RING, btn_snooze -> alarm_on 0; 300 ticks -> alarm_on 1 again, cnt=60.
REQ-034 In A_RING, alm_en 0 -> alarm_on 0 next edge; re-enable within same second -> no retrigger.
REQ-035 rst high during A_SNOOZE with tick and btn_inc asserted -> all outputs at REQ-028 values next edge.
